// File: rtl/serial_add_pkg.sv
// Shared types for the serial-adder scheduler: FSM states, default width, requester ID.
package serial_add_pkg;

    localparam int SA_N = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        RUN  = 3'd2,
        CAPT = 3'd3,
        RESP = 3'd4
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; on a tie the requester not served last wins.
module rr_arb2
    import serial_add_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last,
    output logic [1:0] gnt,
    output req_id_t    sel
);

    always_comb begin
        sel = 1'b0;
        gnt = 2'b00;
        if (req == 2'b11) begin
            sel = ~last;
        end else if (req[1]) begin
            sel = 1'b1;
        end
        if (|req) begin
            gnt = sel ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/serial_add_sched.sv
// Shares one external serial adder between two requesters: arbitrate, clear, N shift cycles,
// capture, then a one-cycle done pulse. Grant to done is N+3 cycles; requests wait while busy.
module serial_add_sched
    import serial_add_pkg::*;
#(
    parameter int N  = SA_N,
    parameter int CW = $clog2(N + 1)
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] b0,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] b1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [N-1:0] res_sum,
    output logic         res_cout,
    output logic         busy,
    output logic [N-1:0] add_a,
    output logic [N-1:0] add_b,
    output logic         add_rst,
    output logic         add_ld,
    input  logic [N-1:0] add_sum,
    input  logic         add_cout
);

    state_t         state;
    logic [CW-1:0]  cnt;
    req_id_t        last;
    req_id_t        sel;
    logic [N-1:0]   op_a;
    logic [N-1:0]   op_b;
    logic [1:0]     arb_gnt;
    req_id_t        arb_sel;
    logic           idle;

    rr_arb2 u_arb (
        .req  ({req1, req0}),
        .last (last),
        .gnt  (arb_gnt),
        .sel  (arb_sel)
    );

    assign idle = (state == IDLE);

    // Outputs are gated by rst so nothing leaks out while the FSM is being aborted.
    assign gnt0    = !rst && idle && arb_gnt[0];
    assign gnt1    = !rst && idle && arb_gnt[1];
    assign done0   = !rst && (state == RESP) && (sel == 1'b0);
    assign done1   = !rst && (state == RESP) && (sel == 1'b1);
    assign busy    = !rst && !idle;
    assign add_ld  = !rst && (state == RUN);
    assign add_rst = rst || (state == CLR);
    assign add_a   = op_a;
    assign add_b   = op_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            last     <= 1'b1;
            sel      <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            res_sum  <= '0;
            res_cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|arb_gnt) begin
                        op_a  <= arb_sel ? a1 : a0;
                        op_b  <= arb_sel ? b1 : b0;
                        sel   <= arb_sel;
                        state <= CLR;
                    end
                end
                CLR: begin
                    cnt   <= CW'(N - 1);
                    state <= RUN;
                end
                RUN: begin
                    // Counter runs N-1 down to 0, giving exactly N shift cycles.
                    if (cnt == '0) begin
                        state <= CAPT;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                CAPT: begin
                    res_sum  <= add_sum;
                    res_cout <= add_cout;
                    state    <= RESP;
                end
                RESP: begin
                    last  <= sel;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sched.sv
// Bench for serial_add_sched: directed scenarios then random traffic against a timeline model.
module tb_serial_add_sched;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1;
    logic [N-1:0] a0, b0, a1, b1;
    logic         gnt0, gnt1, done0, done1;
    logic [N-1:0] res_sum;
    logic         res_cout;
    logic         busy;
    logic [N-1:0] add_a, add_b;
    logic         add_rst, add_ld;
    logic [N-1:0] add_sum;
    logic         add_cout;

    always #5 clk = ~clk;

    serial_add_sched #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .a0       (a0),
        .b0       (b0),
        .a1       (a1),
        .b1       (b1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .done0    (done0),
        .done1    (done1),
        .res_sum  (res_sum),
        .res_cout (res_cout),
        .busy     (busy),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_rst  (add_rst),
        .add_ld   (add_ld),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // Environment serial adder: one bit per load cycle, LSB first, sum shifted in from the top.
    logic [N-1:0] sa_sum;
    logic         sa_c;
    int           sa_k;
    logic         sa_ba, sa_bb;

    always @(posedge clk) begin
        if (add_rst) begin
            sa_sum <= '0;
            sa_c   <= 1'b0;
            sa_k   <= 0;
        end else if (add_ld) begin
            if (sa_k < N) begin
                sa_ba = add_a[sa_k];
                sa_bb = add_b[sa_k];
            end else begin
                sa_ba = 1'b0;
                sa_bb = 1'b0;
            end
            sa_sum <= {sa_ba ^ sa_bb ^ sa_c, sa_sum[N-1:1]};
            sa_c   <= (sa_ba & sa_bb) | (sa_c & (sa_ba ^ sa_bb));
            sa_k   <= sa_k + 1;
        end
    end

    assign add_sum  = sa_sum;
    assign add_cout = sa_c;

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase counts cycles since grant (-1 = idle).
    // 1 = clear, 2..N+1 = shifting, N+2 = capture, N+3 = done.
    int           m_ph   = -1;
    logic         m_last = 1'b1;
    logic         m_sel  = 1'b0;
    logic [N-1:0] m_a    = '0;
    logic [N-1:0] m_b    = '0;
    logic [N:0]   m_res  = '0;
    logic         m_g0   = 1'b0;
    logic         m_g1   = 1'b0;
    int           n_done_m = 0;
    int           n_done_d = 0;
    logic         rnd_mode = 1'b0;

    task automatic tick();
        logic eg0, eg1, pick, e_busy, e_ld, e_rst, e_d0, e_d1;
        @(negedge clk);
        eg0 = 1'b0; eg1 = 1'b0; pick = 1'b0;
        e_busy = 1'b0; e_ld = 1'b0; e_rst = 1'b0; e_d0 = 1'b0; e_d1 = 1'b0;
        if (rst) begin
            e_rst = 1'b1;
        end else if (m_ph < 0) begin
            pick = (req0 && req1) ? ~m_last : req1;
            if (req0 || req1) begin
                eg0 = ~pick;
                eg1 = pick;
            end
        end else begin
            e_busy = 1'b1;
            e_rst  = (m_ph == 1);
            e_ld   = (m_ph >= 2) && (m_ph <= N + 1);
            e_d0   = (m_ph == N + 3) && !m_sel;
            e_d1   = (m_ph == N + 3) && m_sel;
        end
        chk("gnt0", 32'(gnt0), 32'(eg0));
        chk("gnt1", 32'(gnt1), 32'(eg1));
        chk("done0", 32'(done0), 32'(e_d0));
        chk("done1", 32'(done1), 32'(e_d1));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("add_ld", 32'(add_ld), 32'(e_ld));
        chk("add_rst", 32'(add_rst), 32'(e_rst));
        chk("res_sum", 32'(res_sum), 32'(m_res[N-1:0]));
        chk("res_cout", 32'(res_cout), 32'(m_res[N]));
        if (!rst && m_ph > 0) begin
            chk("add_a", 32'(add_a), 32'(m_a));
            chk("add_b", 32'(add_b), 32'(m_b));
        end
        if (done0 || done1) n_done_d++;
        if (e_d0 || e_d1) n_done_m++;

        if (rst) begin
            m_ph = -1;
            m_last = 1'b1;
            m_res = '0;
        end else if (m_ph < 0) begin
            if (req0 || req1) begin
                m_sel = pick;
                m_a   = pick ? a1 : a0;
                m_b   = pick ? b1 : b0;
                m_ph  = 1;
            end
        end else begin
            if (m_ph == N + 2) m_res = {1'b0, m_a} + {1'b0, m_b};
            if (m_ph == N + 3) begin
                m_last = m_sel;
                m_ph = -1;
            end else begin
                m_ph++;
            end
        end
        m_g0 = eg0;
        m_g1 = eg1;
        @(posedge clk);
        #1;
    endtask

    // Requester behaviour after each cycle; operands are scrambled right after a grant.
    task automatic policy();
        if (m_g0) begin
            if (rnd_mode && $urandom_range(1, 0) == 1) begin
                a0 = 8'($urandom); b0 = 8'($urandom);
            end else begin
                req0 = 1'b0;
                a0 = rnd_mode ? 8'($urandom) : 8'h00;
            end
        end else if (rnd_mode && !req0 && $urandom_range(9, 0) < 3) begin
            req0 = 1'b1; a0 = 8'($urandom); b0 = 8'($urandom);
        end
        if (m_g1) begin
            if (rnd_mode && $urandom_range(1, 0) == 1) begin
                a1 = 8'($urandom); b1 = 8'($urandom);
            end else begin
                req1 = 1'b0;
                a1 = rnd_mode ? 8'($urandom) : 8'h00;
            end
        end else if (rnd_mode && !req1 && $urandom_range(9, 0) < 3) begin
            req1 = 1'b1; a1 = 8'($urandom); b1 = 8'($urandom);
        end
        if (rnd_mode) rst = ($urandom_range(99, 0) == 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            policy();
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        do_reset(2);

        // Single request; a0 is zeroed the cycle after its grant.
        req0 = 1'b1; a0 = 8'hEA; b0 = 8'hF3;
        run(16);
        chk("single_sum", 32'(res_sum), 32'h0DD);
        chk("single_cout", 32'(res_cout), 32'h1);

        // Tie straight after reset: requester 0 first, then 1.
        do_reset(1);
        req0 = 1'b1; req1 = 1'b1;
        a0 = 8'h12; b0 = 8'h34; a1 = 8'h01; b1 = 8'hFF;
        run(13);
        chk("tie0_sum", 32'(res_sum), 32'h046);
        chk("tie0_cout", 32'(res_cout), 32'h0);
        run(12);
        chk("tie1_sum", 32'(res_sum), 32'h000);
        chk("tie1_cout", 32'(res_cout), 32'h1);
        run(3);

        // Reset during the 4th shift cycle, then a fresh request from 1.
        req0 = 1'b1; a0 = 8'h5A; b0 = 8'h33;
        run(5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_res", 32'(res_sum), 32'h0);
        req1 = 1'b1; a1 = 8'hFF; b1 = 8'hFF;
        run(14);
        chk("ff_sum", 32'(res_sum), 32'h0FE);
        chk("ff_cout", 32'(res_cout), 32'h1);

        // Request from 1 arriving while 0 is being served.
        req0 = 1'b1; a0 = 8'h80; b0 = 8'h80;
        run(5);
        req1 = 1'b1; a1 = 8'h0F; b1 = 8'hF0;
        run(30);

        rnd_mode = 1'b1;
        run(3000);
        rnd_mode = 1'b0;
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        run(20);

        chk("done_count", 32'(n_done_d), 32'(n_done_m));
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
